// File: rtl/pipeline_mem_arbiter.sv
// Arbitrates the Fetch-stage instruction port and the Memory-stage data port onto one
// variable-latency memory bus. Define MEM_ARB_TIMEOUT_EN to add the bounded-wait watchdog.
module pipeline_mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          IReqF,
  input  logic [AW-1:0] PCF,
  output logic [DW-1:0] InstrF,
  output logic          IRdyF,
  input  logic          FlushF,
  input  logic          DReqM,
  input  logic          MemWriteM,
  input  logic [AW-1:0] ALUOutM,
  input  logic [DW-1:0] WriteDataM,
  output logic [DW-1:0] ReadDataM,
  output logic          DRdyM,
  output logic          MemStall,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          ErrTimeout
);

  // Handshake: a requester holds its req and operands until its 1-cycle rdy pulse (or a
  // flush for fetch); the memory sees mem_req/addr/we/wdata stable until it returns mem_ack.
  typedef enum logic [1:0] {IDLE = 2'd0, IBUSY = 2'd1, DBUSY = 2'd2} state_e;

  state_e        state_q, state_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [DW-1:0] instr_q, instr_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          irdy_q, irdy_d;
  logic          drdy_q, drdy_d;
  logic          squash_q, squash_d;
  logic          last_data_q, last_data_d;

  logic          busy, fetch_ok, grant_d, grant_i, expire, done;
  logic [DW-1:0] resp_data;

  assign busy     = (state_q != IDLE);
  assign fetch_ok = IReqF & ~FlushF;
  assign done     = busy & (mem_ack | expire);
  // A watchdog expiry completes the access with zero data.
  assign resp_data = mem_ack ? mem_rdata : '0;

  // Both pending: data wins unless data had the previous grant.
  always_comb begin
    grant_d = 1'b0;
    grant_i = 1'b0;
    if (state_q == IDLE && !irdy_q && !drdy_q) begin
      grant_d = DReqM & ~(fetch_ok & last_data_q);
      grant_i = fetch_ok & ~grant_d;
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  assign expire = busy & ~mem_ack & (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q | expire;
    if (grant_d || grant_i)   cnt_d = '0;
    else if (busy && !mem_ack) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign ErrTimeout = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT == 0);
  assign expire         = 1'b0;
  assign ErrTimeout     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (grant_d)      state_d = DBUSY;
        else if (grant_i) state_d = IBUSY;
      end
      IBUSY, DBUSY: if (done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    instr_d     = instr_q;
    rdata_d     = rdata_q;
    irdy_d      = 1'b0;
    drdy_d      = 1'b0;
    squash_d    = squash_q;
    last_data_d = last_data_q;
    if (grant_d) begin
      mem_req_d   = 1'b1;
      mem_we_d    = MemWriteM;
      mem_addr_d  = ALUOutM;
      mem_wdata_d = WriteDataM;
    end else if (grant_i) begin
      mem_req_d  = 1'b1;
      mem_we_d   = 1'b0;
      mem_addr_d = PCF;
    end
    if (state_q == IBUSY && FlushF) squash_d = 1'b1;
    if (done) begin
      mem_req_d   = 1'b0;
      squash_d    = 1'b0;
      last_data_d = (state_q == DBUSY);
      if (state_q == DBUSY) begin
        drdy_d = 1'b1;
        if (!mem_we_q) rdata_d = resp_data;
      end else if (!squash_q && !FlushF) begin
        irdy_d  = 1'b1;
        instr_d = resp_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      instr_q     <= '0;
      rdata_q     <= '0;
      irdy_q      <= 1'b0;
      drdy_q      <= 1'b0;
      squash_q    <= 1'b0;
      last_data_q <= 1'b0;
    end else begin
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      instr_q     <= instr_d;
      rdata_q     <= rdata_d;
      irdy_q      <= irdy_d;
      drdy_q      <= drdy_d;
      squash_q    <= squash_d;
      last_data_q <= last_data_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign InstrF    = instr_q;
  assign ReadDataM = rdata_q;
  assign IRdyF     = irdy_q;
  assign DRdyM     = drdy_q;
  assign MemStall  = (DReqM & ~drdy_q) | (IReqF & ~irdy_q & ~FlushF);

endmodule

// File: tb/tb_pipeline_mem_arbiter.sv
// Bench for pipeline_mem_arbiter: directed scenarios, then randomized requesters and memory,
// all compared every cycle against a transaction-level model of the arbiter.
module tb_pipeline_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TIMEOUT = 15;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_req, flush, d_req, we_m, mem_ack;
  logic [AW-1:0] pcf, alu_out;
  logic [DW-1:0] wdata_m, mem_rdata;
  logic [DW-1:0] InstrF, ReadDataM, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic          IRdyF, DRdyM, MemStall, mem_req, mem_we, ErrTimeout;

  pipeline_mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .IReqF(i_req), .PCF(pcf), .InstrF(InstrF), .IRdyF(IRdyF), .FlushF(flush),
    .DReqM(d_req), .MemWriteM(we_m), .ALUOutM(alu_out), .WriteDataM(wdata_m),
    .ReadDataM(ReadDataM), .DRdyM(DRdyM), .MemStall(MemStall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .ErrTimeout(ErrTimeout)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Transaction-level model: one outstanding access plus the pulses it produces.
  logic          m_busy = 0, m_is_data = 0, m_we = 0, m_squash = 0, m_last_data = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0, m_instr = '0, m_rdata = '0;
  logic          m_irdy = 0, m_drdy = 0, m_err = 0;
  int            m_wait = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic check_all();
    check("mem_req", mem_req, m_busy);
    if (m_busy) begin
      check("mem_addr", mem_addr, m_addr);
      check("mem_we", mem_we, m_we);
      if (m_is_data) check("mem_wdata", mem_wdata, m_wdata);
    end
    check("IRdyF", IRdyF, m_irdy);
    check("DRdyM", DRdyM, m_drdy);
    check("InstrF", InstrF, m_instr);
    check("ReadDataM", ReadDataM, m_rdata);
    check("MemStall", MemStall, (d_req & ~m_drdy) | (i_req & ~m_irdy & ~flush));
    check("ErrTimeout", ErrTimeout, m_err);
  endtask

  task automatic model_step();
    logic nx_irdy, nx_drdy, want_i, finish, expired;
    logic [DW-1:0] val;
    nx_irdy = 0; nx_drdy = 0; expired = 0;
    if (reset) begin
      m_busy = 0; m_is_data = 0; m_we = 0; m_squash = 0; m_last_data = 0;
      m_addr = '0; m_wdata = '0; m_instr = '0; m_rdata = '0; m_err = 0; m_wait = 0;
    end else if (!m_busy) begin
      want_i = i_req && !flush;
      if (!m_irdy && !m_drdy) begin
        if (d_req && !(want_i && m_last_data)) begin
          m_busy = 1; m_is_data = 1; m_we = we_m; m_addr = alu_out; m_wdata = wdata_m;
          m_wait = 0; m_squash = 0;
        end else if (want_i) begin
          m_busy = 1; m_is_data = 0; m_we = 0; m_addr = pcf; m_wait = 0; m_squash = 0;
        end
      end
    end else begin
      if (!m_is_data && flush) m_squash = 1;
      if (!mem_ack) m_wait++;
`ifdef MEM_ARB_TIMEOUT_EN
      if (!mem_ack && m_wait == TIMEOUT) expired = 1;
`endif
      finish = mem_ack || expired;
      val = mem_ack ? mem_rdata : '0;
      if (finish) begin
        m_busy = 0;
        m_last_data = m_is_data;
        if (expired) m_err = 1;
        if (m_is_data) begin
          nx_drdy = 1;
          if (!m_we) m_rdata = val;
        end else if (!m_squash) begin
          nx_irdy = 1;
          m_instr = val;
        end
        m_squash = 0;
      end
    end
    m_irdy = nx_irdy;
    m_drdy = nx_drdy;
  endtask

  // Entered at a falling edge with inputs set; leaves at the next falling edge.
  task automatic cycle();
    #1;
    check_all();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic ack_cycle(input logic [DW-1:0] d);
    mem_ack = 1; mem_rdata = d;
    cycle();
    mem_ack = 0; mem_rdata = $urandom;
  endtask

  logic f_on, d_on, prev_busy;
  int   resp_cnt;

  initial begin
    reset = 1; i_req = 0; flush = 0; d_req = 0; we_m = 0; mem_ack = 0;
    pcf = '0; alu_out = '0; wdata_m = '0; mem_rdata = '0;
    @(posedge clk); @(negedge clk);
    cycle();
    reset = 0;
    check("rst_InstrF", InstrF, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_mem_req", mem_req, 1'b0);

    // Plain fetch with a 3-cycle memory
    i_req = 1; pcf = 32'h8;
    cycle(); cycle(); cycle();
    ack_cycle(32'hE3A01005);
    check("t1_irdy", IRdyF, 1'b1);
    check("t1_instr", InstrF, 32'hE3A01005);
    check("t1_model_instr", m_instr, 32'hE3A01005);
    i_req = 0;
    cycle();
    check("t1_pulse_len", IRdyF, 1'b0);

    // Simultaneous requests, previous grant was fetch: data first
    i_req = 1; pcf = 32'h20; d_req = 1; we_m = 1; alu_out = 32'h40; wdata_m = 32'hCAFE;
    cycle();
    check("t2_addr_data", mem_addr, 32'h40);
    check("t2_we", mem_we, 1'b1);
    check("t2_wdata", mem_wdata, 32'hCAFE);
    ack_cycle(32'h99999999);
    check("t2_drdy", DRdyM, 1'b1);
    d_req = 0;
    cycle(); cycle();
    check("t2_addr_fetch", mem_addr, 32'h20);
    check("t2_we_fetch", mem_we, 1'b0);
    ack_cycle(32'h11112222);
    i_req = 0;
    cycle();
    d_req = 1; we_m = 0; alu_out = 32'h44;
    cycle();
    ack_cycle(32'h5555AAAA);
    check("t2_load", ReadDataM, 32'h5555AAAA);
    d_req = 0;
    cycle();
    // Previous grant was data: fetch first
    i_req = 1; pcf = 32'h24; d_req = 1; we_m = 0; alu_out = 32'h48;
    cycle();
    check("t2_fetch_first", mem_addr, 32'h24);
    ack_cycle(32'h0BADF00D);
    i_req = 0;
    cycle(); cycle();
    check("t2_then_data", mem_addr, 32'h48);
    ack_cycle(32'h01020304);
    d_req = 0;
    cycle();

    // Flush while fetch is in flight
    i_req = 1; pcf = 32'h30;
    cycle();
    i_req = 0; flush = 1;
    cycle();
    flush = 0;
    cycle();
    ack_cycle(32'h12345678);
    check("t3_no_irdy", IRdyF, 1'b0);
    check("t3_instr_kept", InstrF, 32'h0BADF00D);
    i_req = 1; pcf = 32'h34;
    cycle();
    check("t3_next_addr", mem_addr, 32'h34);
    ack_cycle(32'hA5A5A5A5);
    check("t3_next_instr", InstrF, 32'hA5A5A5A5);
    i_req = 0;
    cycle();
    // Flush in the same cycle as the ack
    i_req = 1; pcf = 32'h38;
    cycle();
    i_req = 0; flush = 1;
    ack_cycle(32'h77777777);
    flush = 0;
    check("t3_same_cycle", IRdyF, 1'b0);
    check("t3_same_instr", InstrF, 32'hA5A5A5A5);
    cycle();

    // Reset mid-load, then a late ack
    d_req = 1; we_m = 0; alu_out = 32'h100;
    cycle(); cycle();
    check("t4_req", mem_req, 1'b1);
    reset = 1; d_req = 0;
    cycle();
    reset = 0;
    ack_cycle(32'hDEADBEEF);
    check("t4_req_off", mem_req, 1'b0);
    check("t4_drdy", DRdyM, 1'b0);
    check("t4_rdata", ReadDataM, 32'h0);
    check("t4_instr", InstrF, 32'h0);
    check("t4_addr", mem_addr, 32'h0);

    // Memory never answers
    d_req = 1; we_m = 0; alu_out = 32'h104;
    cycle();
    ack_cycle(32'h13579BDF);
    d_req = 0;
    cycle();
    d_req = 1; alu_out = 32'h200;
    cycle();
    repeat (TIMEOUT) cycle();
`ifdef MEM_ARB_TIMEOUT_EN
    check("t5_req_drop", mem_req, 1'b0);
    check("t5_drdy", DRdyM, 1'b1);
    check("t5_rdata0", ReadDataM, 32'h0);
    check("t5_err", ErrTimeout, 1'b1);
    d_req = 0;
    repeat (3) cycle();
    check("t5_err_sticky", ErrTimeout, 1'b1);
`else
    check("t5_req_held", mem_req, 1'b1);
    check("t5_no_err", ErrTimeout, 1'b0);
    check("t5_no_drdy", DRdyM, 1'b0);
    d_req = 0;
`endif
    reset = 1;
    cycle();
    reset = 0;
    check("t5_err_clear", ErrTimeout, 1'b0);

    // Randomized requesters and memory
    f_on = 0; d_on = 0; prev_busy = 0; resp_cnt = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      reset = ($urandom_range(0, 599) == 0);
      if (f_on && m_irdy) f_on = 0;
      if (d_on && m_drdy) d_on = 0;
      flush = ($urandom_range(0, 9) == 0);
      if (flush || reset) f_on = 0;
      if (reset) d_on = 0;
      if (!f_on && $urandom_range(0, 2) == 0) begin
        f_on = 1; pcf = $urandom & 32'hFFFF_FFFC;
      end
      if (!d_on && $urandom_range(0, 3) == 0) begin
        d_on = 1; alu_out = $urandom; wdata_m = $urandom; we_m = 1'($urandom_range(0, 1));
      end
      i_req = f_on; d_req = d_on;
      if (m_busy && !prev_busy) resp_cnt = $urandom_range(0, 4);
      mem_rdata = $urandom;
      if (m_busy) begin
        mem_ack = (resp_cnt == 0);
        if (resp_cnt != 0) resp_cnt--;
      end else begin
        mem_ack = ($urandom_range(0, 7) == 0);
      end
      prev_busy = m_busy;
      cycle();
    end
    mem_ack = 0; i_req = 0; d_req = 0; flush = 0; reset = 0;
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
